button_press_classifier: RTL

//  Consumes the synchronized, debounced button level from the debouncer stage and

---
 rtl/button_pkg.sv | 19 +
 rtl/button_interval_timer.sv | 27 ++
 rtl/button_press_classifier.sv | 121 ++++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared FSM encodings and gesture codes for the button press classifier and its consumers.
package button_pkg;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StPress1   = 3'd1;
    localparam logic [2:0] StWaitGap  = 3'd2;
    localparam logic [2:0] StPress2   = 3'd3;
    localparam logic [2:0] StLongHeld = 3'd4;

    localparam logic [1:0] GestureNone   = 2'd0;
    localparam logic [1:0] GestureShort  = 2'd1;
    localparam logic [1:0] GestureLong   = 2'd2;
    localparam logic [1:0] GestureDouble = 2'd3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_interval_timer.sv
// Up-counter with synchronous load-to-1, increment enable and an equal-to-limit flag.
module button_interval_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= CNT_W'(1);
        end else if (inc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign done = (cnt_q == limit);

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced button gestures into short press, long press and double click pulses.
module button_press_classifier #(
    parameter int unsigned LONG_CYCLES = 500_000,
    parameter int unsigned GAP_CYCLES  = 250_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_level,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic busy
);
    import button_pkg::*;

    localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LongLimit = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] GapLimit  = CNT_W'(GAP_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic             btn_q;
    logic             rise, fall;
    logic             load, inc, done;
    logic [CNT_W-1:0] limit;
    logic             short_d, long_d, double_d;

    assign rise = btn_level & ~btn_q;
    assign fall = ~btn_level & btn_q;

    button_interval_timer #(
        .CNT_W(CNT_W)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .inc  (inc),
        .limit(limit),
        .done (done)
    );

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        inc      = 1'b0;
        limit    = LongLimit;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StPress1;
                    load    = 1'b1;
                end
            end
            StPress1: begin
                if (fall) begin
                    state_d = StWaitGap;
                    load    = 1'b1;
                end else if (btn_level) begin
                    if (done) begin
                        long_d  = 1'b1;
                        state_d = StLongHeld;
                    end else begin
                        inc = 1'b1;
                    end
                end
            end
            StWaitGap: begin
                limit = GapLimit;
                // A new press wins over gap expiry on the same sample.
                if (rise) begin
                    state_d = StPress2;
                    load    = 1'b1;
                end else if (done) begin
                    short_d = 1'b1;
                    state_d = StIdle;
                end else begin
                    inc = 1'b1;
                end
            end
            StPress2: begin
                if (fall) begin
                    double_d = 1'b1;
                    state_d  = StIdle;
                end else if (done) begin
                    double_d = 1'b1;
                    state_d  = StLongHeld;
                end else begin
                    inc = 1'b1;
                end
            end
            StLongHeld: begin
                if (fall) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // btn_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            btn_q        <= 1'b1;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_q      <= state_d;
            btn_q        <= btn_level;
            short_press  <= short_d;
            long_press   <= long_d;
            double_click <= double_d;
            busy         <= (state_d != StIdle);
        end
    end

endmodule
